// File: rtl/safe_lock_ctrl_pkg.sv
// Shared types and constants for the safe keypad lock controller.
package safe_pkg;

    localparam int unsigned PW_W = 16;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SET_PW  = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_LOCK  = 4'hC;
    localparam logic [3:0] KEY_SETPW = 4'hD;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/safe_lock_ctrl_if.sv
// Keypad strobe in, lock status out; slave side is the controller.
interface safe_lock_ctrl_if;
    import safe_pkg::*;

    logic            key_valid;
    logic [3:0]      key_code;
    logic            state;
    logic            alarm;
    logic [1:0]      err_cnt;
    logic [2:0]      digit_cnt;
    logic [PW_W-1:0] entry_digits;
    logic            pw_changed;

    modport master (
        output key_valid, key_code,
        input  state, alarm, err_cnt, digit_cnt, entry_digits, pw_changed
    );

    modport slave (
        input  key_valid, key_code,
        output state, alarm, err_cnt, digit_cnt, entry_digits, pw_changed
    );

endinterface

// File: rtl/safe_lock_ctrl_timer.sv
// Down-counting cycle timer: load a count, expire pulses in the last counted cycle.
module safe_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/safe_lock_ctrl.sv
// Keypad lock FSM: code entry, lockout after repeated failures, password change, idle timeout.
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter logic [PW_W-1:0] DEFAULT_PW     = 16'h1234,
    parameter int unsigned     MAX_TRIES      = 3,
    parameter int unsigned     TIMEOUT_CYCLES = 250000000,
    parameter int unsigned     LOCKOUT_CYCLES = 500000000
) (
    input logic             clk,
    input logic             rst,
    safe_lock_ctrl_if.slave key_if
);

    localparam int unsigned T_MAX     = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                          : LOCKOUT_CYCLES;
    localparam int unsigned TW        = $clog2(T_MAX + 1);
    localparam logic [1:0]  TRIES_LIM = 2'(MAX_TRIES);

    lock_state_e     fsm_q, fsm_d;
    logic [PW_W-1:0] buf_q, buf_d, pw_q, pw_d;
    logic [2:0]      dcnt_q, dcnt_d;
    logic [1:0]      err_q, err_d, err_inc;
    logic            state_q, state_d, alarm_q, alarm_d, pwch_q, pwch_d;
    logic            key_ok, digit, room;
    logic            t_load, t_expire;
    logic [TW-1:0]   t_val;

    safe_cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .load_val_i (t_val),
        .expire_o   (t_expire)
    );

    assign key_ok  = key_if.key_valid && (key_if.key_code <= KEY_SETPW);
    assign digit   = key_if.key_valid && is_digit(key_if.key_code);
    assign room    = (dcnt_q < 3'd4);
    assign err_inc = (err_q == 2'd3) ? err_q : err_q + 2'd1;

    always_comb begin
        fsm_d  = fsm_q;
        buf_d  = buf_q;
        dcnt_d = dcnt_q;
        err_d  = err_q;
        pw_d   = pw_q;
        pwch_d = 1'b0;
        t_load = 1'b1;
        t_val  = '0;

        case (fsm_q)
            ST_LOCKED, ST_ENTRY: begin
                if (digit) begin
                    fsm_d = ST_ENTRY;
                    if (room) begin
                        buf_d  = {buf_q[PW_W-5:0], key_if.key_code};
                        dcnt_d = dcnt_q + 3'd1;
                    end
                end else if (key_ok && key_if.key_code == KEY_CLEAR) begin
                    buf_d  = '0;
                    dcnt_d = '0;
                    fsm_d  = ST_LOCKED;
                end else if (key_ok && key_if.key_code == KEY_ENTER) begin
                    buf_d  = '0;
                    dcnt_d = '0;
                    if (dcnt_q == 3'd4 && buf_q == pw_q) begin
                        fsm_d = ST_OPEN;
                        err_d = '0;
                    end else begin
                        err_d = err_inc;
                        fsm_d = (err_inc >= TRIES_LIM) ? ST_LOCKOUT : ST_LOCKED;
                    end
                end else if (fsm_q == ST_ENTRY && t_expire) begin
                    buf_d  = '0;
                    dcnt_d = '0;
                    fsm_d  = ST_LOCKED;
                end
            end
            ST_OPEN: begin
                if (key_ok && key_if.key_code == KEY_LOCK) begin
                    fsm_d = ST_LOCKED;
                end else if (key_ok && key_if.key_code == KEY_SETPW) begin
                    fsm_d = ST_SET_PW;
                end
            end
            ST_SET_PW: begin
                if (digit) begin
                    if (room) begin
                        buf_d  = {buf_q[PW_W-5:0], key_if.key_code};
                        dcnt_d = dcnt_q + 3'd1;
                    end
                end else if (key_ok && key_if.key_code == KEY_CLEAR) begin
                    buf_d  = '0;
                    dcnt_d = '0;
                    fsm_d  = ST_OPEN;
                end else if (key_ok && key_if.key_code == KEY_ENTER) begin
                    if (dcnt_q == 3'd4) begin
                        pw_d   = buf_q;
                        pwch_d = 1'b1;
                        buf_d  = '0;
                        dcnt_d = '0;
                        fsm_d  = ST_OPEN;
                    end
                end else if (t_expire) begin
                    buf_d  = '0;
                    dcnt_d = '0;
                    fsm_d  = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (t_expire) begin
                    fsm_d = ST_LOCKED;
                    err_d = '0;
                end
            end
            default: begin
                fsm_d  = ST_LOCKED;
                buf_d  = '0;
                dcnt_d = '0;
            end
        endcase

        // One shared timer: armed on entry to a timed state, reloaded by keys, held at zero otherwise.
        if (fsm_d == ST_LOCKOUT) begin
            t_load = (fsm_q != ST_LOCKOUT);
            t_val  = TW'(LOCKOUT_CYCLES);
        end else if (fsm_d == ST_ENTRY || fsm_d == ST_SET_PW) begin
            t_load = (fsm_d != fsm_q) || key_ok;
            t_val  = TW'(TIMEOUT_CYCLES);
        end

        state_d = (fsm_d == ST_OPEN) || (fsm_d == ST_SET_PW);
        alarm_d = (fsm_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_LOCKED;
            buf_q   <= '0;
            dcnt_q  <= '0;
            err_q   <= '0;
            pw_q    <= DEFAULT_PW;
            pwch_q  <= 1'b0;
            state_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            buf_q   <= buf_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
            pw_q    <= pw_d;
            pwch_q  <= pwch_d;
            state_q <= state_d;
            alarm_q <= alarm_d;
        end
    end

    assign key_if.state        = state_q;
    assign key_if.alarm        = alarm_q;
    assign key_if.err_cnt      = err_q;
    assign key_if.digit_cnt    = dcnt_q;
    assign key_if.entry_digits = buf_q;
    assign key_if.pw_changed   = pwch_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed and random key sequences checked against a queue-based model of the lock rules.
module tb_safe_lock_ctrl;

    localparam int unsigned T_CYC = 20;
    localparam int unsigned L_CYC = 50;
    localparam int unsigned TRIES = 3;
    localparam logic [3:0]  K_ENTER = 4'hA;
    localparam logic [3:0]  K_CLEAR = 4'hB;
    localparam logic [3:0]  K_LOCK  = 4'hC;
    localparam logic [3:0]  K_SETPW = 4'hD;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    safe_lock_ctrl_if io ();

    safe_lock_ctrl #(
        .DEFAULT_PW     (16'h1234),
        .MAX_TRIES      (TRIES),
        .TIMEOUT_CYCLES (T_CYC),
        .LOCKOUT_CYCLES (L_CYC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (io.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: open/setting flags, a digit queue and plain countdowns.
    logic [3:0]  m_digits[$];
    bit          m_open, m_setting, m_pulse;
    int          m_lock_left, m_idle, m_errs;
    logic [15:0] m_pw;

    function automatic logic [15:0] mval();
        logic [15:0] v = '0;
        foreach (m_digits[i]) v = {v[11:0], m_digits[i]};
        return v;
    endfunction

    function automatic logic [23:0] model_vec();
        return {m_open, (m_lock_left > 0), 2'(m_errs), 3'(m_digits.size()), mval(), m_pulse};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {io.state, io.alarm, io.err_cnt, io.digit_cnt, io.entry_digits, io.pw_changed};
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_open = 0; m_setting = 0; m_pulse = 0;
        m_lock_left = 0; m_idle = 0; m_errs = 0;
        m_pw = 16'h1234;
    endtask

    task automatic model_step(input logic v, input logic [3:0] k);
        bit is_key, is_dig;
        is_key  = v && (k <= 4'hD);
        is_dig  = v && (k <= 4'h9);
        m_pulse = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_errs = 0;
        end else if (!m_open) begin
            if (is_dig) begin
                if (m_digits.size() < 4) m_digits.push_back(k);
                m_idle = T_CYC;
            end else if (is_key && k == K_CLEAR) begin
                m_digits.delete();
            end else if (is_key && k == K_ENTER) begin
                if (m_digits.size() == 4 && mval() == m_pw) begin
                    m_open = 1;
                    m_errs = 0;
                end else begin
                    if (m_errs < 3) m_errs++;
                    if (m_errs >= TRIES) m_lock_left = L_CYC;
                end
                m_digits.delete();
            end else if (m_digits.size() > 0) begin
                if (is_key) m_idle = T_CYC;
                else begin
                    m_idle--;
                    if (m_idle == 0) m_digits.delete();
                end
            end
        end else if (!m_setting) begin
            if (is_key && k == K_LOCK) m_open = 0;
            else if (is_key && k == K_SETPW) begin
                m_setting = 1;
                m_idle = T_CYC;
            end
        end else begin
            if (is_dig) begin
                if (m_digits.size() < 4) m_digits.push_back(k);
                m_idle = T_CYC;
            end else if (is_key && k == K_CLEAR) begin
                m_digits.delete();
                m_setting = 0;
            end else if (is_key && k == K_ENTER && m_digits.size() == 4) begin
                m_pw = mval();
                m_pulse = 1;
                m_digits.delete();
                m_setting = 0;
            end else if (is_key) begin
                m_idle = T_CYC;
            end else begin
                m_idle--;
                if (m_idle == 0) begin
                    m_digits.delete();
                    m_setting = 0;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        checks++;
        assert (dut_vec() === model_vec()) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, dut_vec(), model_vec());
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] k);
        io.key_valid = v;
        io.key_code  = k;
        model_step(v, k);
        @(posedge clk);
        #1;
        io.key_valid = 1'b0;
        compare("cycle");
    endtask

    task automatic press(input logic [3:0] k);
        cyc(1'b1, k);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc(1'b0, 4'h0);
    endtask

    task automatic code(input logic [15:0] c);
        press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        io.key_valid = 1'b0;
        io.key_code  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        compare("reset");
        chk("rst_out", {io.state, io.alarm, io.err_cnt, io.digit_cnt, io.entry_digits, io.pw_changed}, 0);
    endtask

    initial begin
        do_reset();

        // Correct default code opens one cycle after ENTER
        code(16'h1234); press(K_ENTER);
        chk("t1_state", io.state, 1); chk("t1_err", io.err_cnt, 0);
        press(K_LOCK);
        chk("t1_lock", io.state, 0);

        // Three failures trigger a 50-cycle lockout
        code(16'h1235); press(K_ENTER); chk("t2_err1", io.err_cnt, 1);
        code(16'h1235); press(K_ENTER); chk("t2_err2", io.err_cnt, 2);
        chk("t2_noalarm", io.alarm, 0);
        code(16'h1235); press(K_ENTER); chk("t2_alarm", io.alarm, 1);
        repeat (L_CYC - 1) cyc(1'b1, 4'($urandom_range(0, 15)));
        chk("t2_still", io.alarm, 1); chk("t2_dcnt", io.digit_cnt, 0);
        idle(1);
        chk("t2_release", {io.alarm, io.err_cnt, io.state}, 0);

        // Password change while open
        code(16'h1234); press(K_ENTER);
        press(K_SETPW); chk("t3_setpw_state", io.state, 1);
        code(16'h9876); press(K_ENTER);
        chk("t3_pulse", io.pw_changed, 1);
        idle(1); chk("t3_pulse_end", io.pw_changed, 0);
        press(K_LOCK);
        code(16'h1234); press(K_ENTER);
        chk("t3_old_fails", {io.state, io.err_cnt}, 3'b001);
        code(16'h9876); press(K_ENTER);
        chk("t3_new_opens", {io.state, io.err_cnt}, 3'b100);

        // Digit overflow, CLEAR, short ENTER
        press(K_LOCK);
        code(16'h1234); press(4'h5);
        chk("t5_dcnt", io.digit_cnt, 4); chk("t5_buf", io.entry_digits, 16'h1234);
        press(K_CLEAR);
        chk("t5_clear", {io.digit_cnt, io.entry_digits}, 0);
        press(4'h1); press(4'h2); press(K_ENTER);
        chk("t5_short", io.err_cnt, 1);

        // Entry timeout, and a key in the expiry cycle winning
        press(4'h1); press(4'h2);
        idle(T_CYC - 1); chk("t4_before", io.digit_cnt, 2);
        idle(1);
        chk("t4_expired", {io.state, io.digit_cnt, io.err_cnt}, 6'b0_000_01);
        press(4'h1); press(4'h2);
        idle(T_CYC - 1); press(4'h3);
        chk("t4_key_wins", io.entry_digits, 16'h0123);
        idle(T_CYC); chk("t4_expired2", io.digit_cnt, 0);

        // Random sessions
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin code(m_pw); press(K_ENTER); end
                2: begin code(16'($urandom)); press(K_ENTER); end
                3: press(K_LOCK);
                4: begin
                    press(K_SETPW);
                    for (int d = 0; d < 4; d++) press(4'($urandom_range(0, 9)));
                    press(K_ENTER);
                end
                5: idle($urandom_range(1, 25));
                default: cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            endcase
        end

        // Reset aborts lockout and a pending password change
        do_reset();
        repeat (3) begin code(16'h5555); press(K_ENTER); end
        chk("t6_in_lockout", io.alarm, 1);
        idle(5);
        do_reset();
        code(16'h1234); press(K_ENTER);
        press(K_SETPW); code(16'h4321); press(K_ENTER);
        press(K_SETPW); press(4'h9); press(4'h8);
        do_reset();
        code(16'h1234); press(K_ENTER);
        chk("t6_default_pw", io.state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
